teclado_scan_ctrl: RTL and testbench
====================================

Name: teclado_scan_ctrl

Overview:
Scan and sequencing controller for the 4x4 matrix keypad. It drives one keypad column low at a time and samples the four row inputs through a synchronizer. It debounces both press and release, encodes the pressed key as {row,col}, and presents it on a valid/ready handshake. It sits between the keypad pins and the downstream BCD/display logic, and replaces free-running scanning with a controlled, debounced scan.

Parameters:
SCAN_DIV, 4, clock cycles per scan tick (column dwell time); must be >= 4.
DEBOUNCE_CNT, 3, consecutive identical tick samples required to accept a press or a release; must be >= 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-low (rst=0 resets).
scan_en  input  1  1 = scanning enabled.
entrada_teclado  input  4  keypad rows, active-low (idle 4'b1111), asynchronous to clk.
saida_conf_teclado  output  4  column drive, one-hot-low (4'b1110 = col0 ... 4'b0111 = col3), registered.
key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the accepted key.
key_valid  output  1  key_code holds an unconsumed key.
key_ready  input  1  consumer accepts key_code when key_valid=1 on the same edge.
overrun  output  1  1-cycle pulse: a key was accepted while the previous key was unconsumed; the new key is dropped.
busy  output  1  1 when state != SCAN.

Behaviour:
- Reset values: saida_conf_teclado=4'b1111, key_code=0, key_valid=0, overrun=0, busy=0, state=SCAN, col=0, div=0, deb=0, row synchronizer=4'b1111.
- Rows pass through a 2-FF synchronizer. All decisions use the synchronized value (rs).
- Tick generation:
  - div counts 0..SCAN_DIV-1 and wraps.
  - tick = (div==SCAN_DIV-1).
  - div resets to 0 whenever the column changes.
- saida_conf_teclado is registered as: scan_en ? ~(4'b1<<col) : 4'b1111.
- row_idx = lowest index i with rs[i]==0. A multi-row press resolves to the lowest row.
- State machine:
  - SCAN, on tick:
    - If rs != 4'b1111: latch col and row_idx, set deb=1, go to DEB_PRESS. The column stays frozen.
    - Else: col = col+1 mod 4 (3 wraps to 0).
  - DEB_PRESS, on tick:
    - If rs != 4'b1111 and row_idx equals the latched row: deb++. When deb reaches DEBOUNCE_CNT, accept the key and go to HELD.
    - Otherwise: advance col and go to SCAN. This covers bounce, release, and a different row.
    - With DEBOUNCE_CNT=1, acceptance happens on the first DEB_PRESS tick.
  - HELD (column frozen), on tick:
    - If rs==4'b1111: deb++.
    - Else: deb=0.
    - When deb reaches DEBOUNCE_CNT: advance col and go to SCAN.
    - Deb is cleared on entry to HELD. A held key never produces a second accept.
- Accept event, same edge as the transition to HELD:
  - key_valid=0, or key_ready=1 on that edge: key_code <= {row,col}, key_valid <= 1.
  - Otherwise: key_code is unchanged, overrun=1 for one cycle.
- Handshake:
  - key_valid && key_ready with no simultaneous accept: key_valid <= 0 on the next edge.
  - key_valid stays high until accepted.
  - key_ready while key_valid=0 is ignored.
- scan_en=0:
  - On the next edge: state=SCAN, col=0, div=0, deb=0, saida=4'b1111.
  - key_valid and key_code are retained, and the handshake still works.
  - An in-progress debounce is aborted with no accept.
- Reset mid-operation returns everything to the reset values immediately (asynchronous). A pending key is lost.
- Latency: from the column edge driving a pressed key to key_valid = SCAN_DIV*DEBOUNCE_CNT cycles, plus the synchronizer settling within the first dwell.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, bench keypad model: row r low iff saida bit c low for the pressed key):
1. Hold rst=0 with scan_en=1 -> saida=4'b1111, key_valid=0, busy=0. Release rst -> saida cycles 1110, 1101, 1011, 0111, 1110, each held for 4 clocks.
2. Press row1/col2 and hold, key_ready=0 -> key_code=4'b0110 and key_valid=1 about 12 clocks after saida=4'b1011 appears; saida stays frozen at 1011 and key_valid stays 1.
3. From scenario 2, pulse key_ready for 1 clock -> key_valid=0 next edge; while the key is held, no new valid. Release -> after 3 idle ticks, busy=0 and saida advances to 0111.
4. Bounce: row0/col0 that toggles pressed/released every 4 clocks -> key_valid never asserts and scanning continues.
5. Overrun: accept row2/col1 (code 4'b1001) without key_ready, release it, then press row3/col3 -> overrun pulses once, key_code stays 4'b1001. Then pulse key_ready together with a fresh row3/col3 accept -> key_code=4'b1111 and key_valid stays 1.
6. Abort: drop scan_en, and separately assert rst=0, during DEB_PRESS -> no key_valid; state returns to SCAN/col0 and saida=4'b1111.

Source files
------------

// File: rtl/teclado_scan_ctrl.sv
// 4x4 keypad scan controller: drives one column low per dwell, debounces press and
// release on the synchronized rows, and hands out {row,col} codes over valid/ready.
module teclado_scan_ctrl #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic [3:0] entrada_teclado,
  output logic [3:0] saida_conf_teclado,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEB_PRESS,
    ST_HELD
  } state_t;

  state_t           state;
  logic [3:0]       rs_p0;
  logic [3:0]       rs_p1;
  logic [DIV_W-1:0] div;
  logic [1:0]       col;
  logic [1:0]       lat_row;
  logic [DEB_W-1:0] deb;

  logic             tick;
  logic             any_row;
  logic [1:0]       row_idx;
  logic [DEB_W:0]   deb_inc;
  logic             deb_done;
  logic             row_match;
  logic             accept;

  // stage p0/p1: two-flop synchronizer for the asynchronous row pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_p0 <= 4'b1111;
      rs_p1 <= 4'b1111;
    end else begin
      rs_p0 <= entrada_teclado;
      rs_p1 <= rs_p0;
    end
  end

  assign tick      = (div == DIV_W'(SCAN_DIV - 1));
  assign any_row   = (rs_p1 != 4'b1111);
  assign deb_inc   = {1'b0, deb} + (DEB_W + 1)'(1);
  assign deb_done  = (deb_inc >= (DEB_W + 1)'(DEBOUNCE_CNT));
  assign row_match = any_row && (row_idx == lat_row);
  assign accept    = scan_en && tick && (state == ST_DEB_PRESS) && row_match && deb_done;

  // Lowest active row wins when several rows are pulled low together.
  always_comb begin
    row_idx = 2'd3;
    if (!rs_p1[2]) row_idx = 2'd2;
    if (!rs_p1[1]) row_idx = 2'd1;
    if (!rs_p1[0]) row_idx = 2'd0;
  end

  // stage p2: scan sequencing, debounce FSM and output handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= ST_SCAN;
      div                <= '0;
      col                <= 2'd0;
      lat_row            <= 2'd0;
      deb                <= '0;
      saida_conf_teclado <= 4'b1111;
      key_code           <= 4'd0;
      key_valid          <= 1'b0;
      overrun            <= 1'b0;
      busy               <= 1'b0;
    end else begin
      overrun <= 1'b0;

      if (key_valid && key_ready) key_valid <= 1'b0;

      // A new key only replaces the old one if the consumer takes the old one now.
      if (accept) begin
        if (!key_valid || key_ready) begin
          key_code  <= {lat_row, col};
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      if (!scan_en) begin
        state              <= ST_SCAN;
        div                <= '0;
        col                <= 2'd0;
        deb                <= '0;
        saida_conf_teclado <= 4'b1111;
        busy               <= 1'b0;
      end else begin
        saida_conf_teclado <= ~(4'b0001 << col);
        div                <= tick ? '0 : div + DIV_W'(1);

        if (tick) begin
          case (state)
            ST_SCAN: begin
              if (any_row) begin
                lat_row <= row_idx;
                deb     <= DEB_W'(1);
                state   <= ST_DEB_PRESS;
                busy    <= 1'b1;
              end else begin
                col <= col + 2'd1;
              end
            end
            ST_DEB_PRESS: begin
              if (row_match) begin
                if (deb_done) begin
                  deb   <= '0;
                  state <= ST_HELD;
                end else begin
                  deb <= deb_inc[DEB_W-1:0];
                end
              end else begin
                col   <= col + 2'd1;
                deb   <= '0;
                state <= ST_SCAN;
                busy  <= 1'b0;
              end
            end
            ST_HELD: begin
              if (any_row) begin
                deb <= '0;
              end else if (deb_done) begin
                col   <= col + 2'd1;
                deb   <= '0;
                state <= ST_SCAN;
                busy  <= 1'b0;
              end else begin
                deb <= deb_inc[DEB_W-1:0];
              end
            end
            default: begin
              state <= ST_SCAN;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_teclado_scan_ctrl.sv
// Directed bench for teclado_scan_ctrl with a behavioural 4x4 keypad model.
module tb_teclado_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_en;
  logic       key_ready;
  logic [3:0] entrada;
  logic [3:0] saida;
  logic [3:0] key_code;
  logic       key_valid;
  logic       overrun;
  logic       busy;

  logic       pressed;
  logic [3:0] pmask;
  logic [1:0] pcol;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Rows in pmask read low only while the pressed key's column is driven low.
  assign entrada = (pressed && !saida[pcol]) ? ~pmask : 4'b1111;

  teclado_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk               (clk),
    .rst               (rst),
    .scan_en           (scan_en),
    .entrada_teclado   (entrada),
    .saida_conf_teclado(saida),
    .key_code          (key_code),
    .key_valid         (key_valid),
    .key_ready         (key_ready),
    .overrun           (overrun),
    .busy              (busy)
  );

  typedef struct {
    logic [3:0] mask;
    logic [1:0] col;
    logic [3:0] code;
    logic [3:0] frozen;
    int         lat;
    logic [3:0] next_saida;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input string nm);
    int k;
    k = 0;
    while (busy !== lvl && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(nm, 32'(busy === lvl), 32'd1);
  endtask

  task automatic reset_with_key(input logic [3:0] m, input logic [1:0] c, input logic p);
    rst     = 1'b0;
    scan_en = 1'b1;
    key_ready = 1'b0;
    pressed = 1'b0;
    repeat (3) @(negedge clk);
    pmask   = m;
    pcol    = c;
    pressed = p;
    rst     = 1'b1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (key_valid) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int nv;
    int nov;
    int saw_last;
    int saw_busy;
    logic [3:0] exp_s;

    rst = 1'b0; scan_en = 1'b1; key_ready = 1'b0;
    pressed = 1'b0; pmask = 4'b0000; pcol = 2'd0;

    // Reset state and free-running column sequence
    repeat (3) @(negedge clk);
    check("rst_saida", 32'(saida), 32'h000F);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_s = ~(4'b0001 << (((k - 1) / 4) % 4));
      check("scan_seq", 32'(saida), 32'(exp_s));
    end

    // Key table: mask of low rows, column, code, frozen drive, latency, drive after release
    tbl[0] = '{4'b0001, 2'd0, 4'b0000, 4'b1110, 12, 4'b1101};
    tbl[1] = '{4'b0010, 2'd2, 4'b0110, 4'b1011, 20, 4'b0111};
    tbl[2] = '{4'b0100, 2'd1, 4'b1001, 4'b1101, 16, 4'b1011};
    tbl[3] = '{4'b1000, 2'd3, 4'b1111, 4'b0111, 24, 4'b1110};
    tbl[4] = '{4'b0001, 2'd3, 4'b0011, 4'b0111, 24, 4'b1110};
    tbl[5] = '{4'b1000, 2'd0, 4'b1100, 4'b1110, 12, 4'b1101};
    tbl[6] = '{4'b1010, 2'd1, 4'b0101, 4'b1101, 16, 4'b1011};

    for (int i = 0; i < 7; i++) begin
      reset_with_key(tbl[i].mask, tbl[i].col, 1'b1);
      wait_valid(n);
      check($sformatf("lat[%0d]", i), 32'(n), 32'(tbl[i].lat));
      check($sformatf("code[%0d]", i), 32'(key_code), 32'(tbl[i].code));
      check($sformatf("frozen[%0d]", i), 32'(saida), 32'(tbl[i].frozen));
      check($sformatf("busy_held[%0d]", i), 32'(busy), 32'd1);
      repeat (8) @(negedge clk);
      check($sformatf("valid_hold[%0d]", i), 32'(key_valid), 32'd1);
      check($sformatf("frozen2[%0d]", i), 32'(saida), 32'(tbl[i].frozen));
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      check($sformatf("consumed[%0d]", i), 32'(key_valid), 32'd0);
      nv = 0;
      repeat (24) begin
        @(negedge clk);
        nv += int'(key_valid);
      end
      check($sformatf("no_reaccept[%0d]", i), 32'(nv), 32'd0);
      pressed = 1'b0;
      wait_busy(1'b0, $sformatf("release[%0d]", i));
      @(negedge clk);
      check($sformatf("advance[%0d]", i), 32'(saida), 32'(tbl[i].next_saida));
    end

    // Bounce on row0/col0: toggles every 4 clocks, never three stable ticks
    reset_with_key(4'b0001, 2'd0, 1'b1);
    nv = 0; saw_last = 0; saw_busy = 0;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      nv += int'(key_valid);
      if (saida == 4'b0111) saw_last = 1;
      if (busy) saw_busy = 1;
      if (k % 4 == 0) pressed = ~pressed;
    end
    check("bounce_valid", 32'(nv), 32'd0);
    check("bounce_scan", 32'(saw_last), 32'd1);
    check("bounce_deb", 32'(saw_busy), 32'd1);

    // Overrun: second key while first is unconsumed
    reset_with_key(4'b0100, 2'd1, 1'b1);
    wait_valid(n);
    check("ovr_first_code", 32'(key_code), 32'h9);
    pressed = 1'b0;
    wait_busy(1'b0, "ovr_rel1");
    pmask = 4'b1000; pcol = 2'd3; pressed = 1'b1;
    nov = 0;
    repeat (80) begin
      @(negedge clk);
      nov += int'(overrun);
    end
    check("ovr_pulses", 32'(nov), 32'd1);
    check("ovr_code_kept", 32'(key_code), 32'h9);
    check("ovr_valid_kept", 32'(key_valid), 32'd1);
    pressed = 1'b0;
    wait_busy(1'b0, "ovr_rel2");
    pressed = 1'b1;
    wait_busy(1'b1, "ovr_deb");
    repeat (7) @(negedge clk);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check("swap_valid", 32'(key_valid), 32'd1);
    check("swap_code", 32'(key_code), 32'hF);
    check("swap_no_ovr", 32'(overrun), 32'd0);

    // Abort during DEB_PRESS: scan_en drop, then asynchronous reset
    reset_with_key(4'b0010, 2'd2, 1'b1);
    wait_busy(1'b1, "abort_deb1");
    scan_en = 1'b0;
    @(negedge clk);
    check("dis_busy", 32'(busy), 32'd0);
    check("dis_saida", 32'(saida), 32'hF);
    nv = 0;
    repeat (20) begin
      @(negedge clk);
      nv += int'(key_valid);
    end
    check("dis_no_valid", 32'(nv), 32'd0);
    scan_en = 1'b1;
    @(negedge clk);
    check("en_col0", 32'(saida), 32'hE);
    wait_busy(1'b1, "abort_deb2");
    rst = 1'b0;
    #1;
    check("arst_saida", 32'(saida), 32'hF);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(key_valid), 32'd0);
    pressed = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      nv += int'(key_valid);
    end
    check("arst_no_valid", 32'(nv), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
